// File: rtl/spk_out_mc_if.sv
// Spike-in / flit-out handshake bundle for spk_out_mc.
// Ports: soma_fire/soma_neuid/soma_ready (spike push), credit_in/flit_out_wr/flit_out (NI side).
interface spk_out_mc_if #(
    parameter int CH = 4,
    parameter int SW = 24,
    parameter int FW = 59
);
    logic [CH-1:0]    soma_fire;
    logic [CH*SW-1:0] soma_neuid;
    logic [CH-1:0]    soma_ready;
    logic             credit_in;
    logic             flit_out_wr;
    logic [FW-1:0]    flit_out;

    modport master (
        output soma_fire, soma_neuid, credit_in,
        input  soma_ready, flit_out_wr, flit_out
    );

    modport slave (
        input  soma_fire, soma_neuid, credit_in,
        output soma_ready, flit_out_wr, flit_out
    );
endinterface

// File: rtl/spk_out_mc.sv
// Multi-channel spike output: RR spike/config push into a shared FIFO,
// per-channel destination-table fanout, credit-gated flit issue.
// Ports: clk, rst (async high), port (spike + flit bundle),
// cfg_we/cfg_wdata/cfg_full (config flit push), cfg_base_* (channel base),
// cfg_dst_* (table write / arbitrated read), sent_cnt (saturating flit count).
module spk_out_mc #(
    parameter int CH        = 4,
    parameter int CHW       = 2,
    parameter int FW        = 59,
    parameter int FTW       = 3,
    parameter int SW        = 24,
    parameter int R_FLG     = 36,
    parameter int DW        = 20,
    parameter int DST_DEPTH = 4,
    parameter int B         = 4,
    parameter int CRED_INIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    spk_out_mc_if.slave          port,
    input  logic                 cfg_we,
    input  logic [FW-1:0]        cfg_wdata,
    output logic                 cfg_full,
    input  logic                 cfg_base_we,
    input  logic [CHW-1:0]       cfg_base_ch,
    input  logic [DST_DEPTH-1:0] cfg_base_wdata,
    input  logic                 cfg_dst_we,
    input  logic [DST_DEPTH-1:0] cfg_dst_waddr,
    input  logic [DW:0]          cfg_dst_wdata,
    input  logic                 cfg_dst_re,
    input  logic [DST_DEPTH-1:0] cfg_dst_raddr,
    output logic                 cfg_dst_rready,
    output logic                 cfg_dst_rvalid,
    output logic [DW:0]          cfg_dst_rdata,
    output logic [15:0]          sent_cnt
);
    localparam int EW = CHW + FW;
    localparam int DEP = 1 << B;
    localparam int TN = 1 << DST_DEPTH;
    localparam logic [B:0] FULL_CNT = (B+1)'(DEP);
    localparam logic [FTW-1:0] READ_T = '1;
    localparam logic [DST_DEPTH-1:0] FAN_MAX = '1;
    localparam logic [B-1:0] CRED_MAX = '1;

    typedef enum logic [1:0] {IDLE, RD, ISSUE, RAW} state_t;

    logic [EW-1:0]        fifo_mem [DEP];
    logic [B-1:0]         wr_ptr, rd_ptr;
    logic [B:0]           count;
    logic                 push, pop, full, empty;
    logic [EW-1:0]        push_data, fifo_head;
    logic [CHW-1:0]       rr, rot, gnt_idx;
    logic                 found, spk_ok;
    logic [DST_DEPTH-1:0] base [CH];
    logic [DW:0]          tbl [TN];
    logic [DW:0]          dat;
    logic [B-1:0]         cred;
    logic                 cfg_acc, fsm_rd, issue;
    logic [FW-1:0]        flit_n, flit_q;
    logic                 wr_q;
    logic [DST_DEPTH-1:0] rd_addr;

    state_t               state, state_n;
    logic [EW-1:0]        head, head_n;
    logic [DST_DEPTH-1:0] ptr, ptr_n, fan, fan_n;

    assign full      = count == FULL_CNT;
    assign empty     = count == '0;
    assign cfg_full  = full;
    assign fifo_head = fifo_mem[rd_ptr];

    // Scan downward so the channel closest to rr is the last (winning) hit.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        rot     = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            rot = CHW'((int'(rr) + k) % CH);
            if (port.soma_fire[rot]) begin
                found   = 1'b1;
                gnt_idx = rot;
            end
        end
    end

    // Config push wins; grant is also masked while in reset.
    assign spk_ok = found && !cfg_we && !full && !rst;
    assign port.soma_ready = spk_ok ? (CH'(1) << gnt_idx) : '0;
    assign push = (cfg_we && !full) || spk_ok;
    assign push_data = cfg_we ? {CHW'(0), cfg_wdata}
        : {gnt_idx, (FW-SW)'(0), port.soma_neuid[int'(gnt_idx)*SW +: SW]};

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{B{1'b0}}, push} - {{B{1'b0}}, pop};
            if (spk_ok)
                rr <= (gnt_idx == CHW'(CH-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            head  <= '0;
            ptr   <= '0;
            fan   <= '0;
        end else begin
            state <= state_n;
            head  <= head_n;
            ptr   <= ptr_n;
            fan   <= fan_n;
        end
    end

    always_comb begin
        state_n = state;
        head_n  = head;
        ptr_n   = ptr;
        fan_n   = fan;
        pop     = 1'b0;
        issue   = 1'b0;
        fsm_rd  = 1'b0;
        flit_n  = '0;
        unique case (state)
            IDLE: if (!empty) begin
                pop    = 1'b1;
                head_n = fifo_head;
                if (fifo_head[FW-1 -: FTW] == READ_T) begin
                    state_n = RAW;
                end else begin
                    // Config entries carry ch=0, so they use base[0].
                    ptr_n   = base[fifo_head[EW-1 -: CHW]];
                    fan_n   = '0;
                    state_n = RD;
                end
            end
            RD: begin
                fsm_rd  = 1'b1;
                state_n = ISSUE;
            end
            ISSUE: if (cred != '0) begin
                issue  = 1'b1;
                flit_n = {head[FW-1 -: FTW], dat[DW:1], head[R_FLG-1:0]};
                if (dat[0] || fan == FAN_MAX) begin
                    state_n = IDLE;
                end else begin
                    ptr_n   = ptr + 1'b1;
                    fan_n   = fan + 1'b1;
                    state_n = RD;
                end
            end
            RAW: if (cred != '0) begin
                issue   = 1'b1;
                flit_n  = head[FW-1:0];
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Single table read port; the FSM owns it in RD. Separate capture
    // registers keep fanout data stable while config reads proceed.
    assign cfg_dst_rready = state != RD;
    assign cfg_acc = cfg_dst_re && cfg_dst_rready;
    assign rd_addr = fsm_rd ? ptr : cfg_dst_raddr;

    always_ff @(posedge clk) begin
        if (cfg_dst_we) tbl[cfg_dst_waddr] <= cfg_dst_wdata;
        if (fsm_rd) dat <= tbl[rd_addr];
        if (cfg_acc) cfg_dst_rdata <= tbl[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) base[i] <= '0;
            cred           <= B'(CRED_INIT);
            flit_q         <= '0;
            wr_q           <= 1'b0;
            cfg_dst_rvalid <= 1'b0;
            sent_cnt       <= '0;
        end else begin
            if (cfg_base_we) base[cfg_base_ch] <= cfg_base_wdata;
            if (port.credit_in && !issue && cred != CRED_MAX)
                cred <= cred + 1'b1;
            else if (issue && !port.credit_in)
                cred <= cred - 1'b1;
            wr_q <= issue;
            if (issue) flit_q <= flit_n;
            if (issue && sent_cnt != 16'hFFFF) sent_cnt <= sent_cnt + 1'b1;
            cfg_dst_rvalid <= cfg_acc;
        end
    end

    assign port.flit_out    = flit_q;
    assign port.flit_out_wr = wr_q;
endmodule

// File: tb/tb_spk_out_mc.sv
// Directed self-checking bench for spk_out_mc.
// Ports: drives all DUT inputs through spk_out_mc_if and plain cfg signals.
module tb_spk_out_mc;
    localparam int FW = 59;
    localparam int DW = 20;
    localparam int SW = 24;
    localparam int CH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spk_out_mc_if #(.CH(CH), .SW(SW), .FW(FW)) bus ();

    logic          cfg_we;
    logic [FW-1:0] cfg_wdata;
    logic          cfg_full;
    logic          cfg_base_we;
    logic [1:0]    cfg_base_ch;
    logic [3:0]    cfg_base_wdata;
    logic          cfg_dst_we;
    logic [3:0]    cfg_dst_waddr;
    logic [DW:0]   cfg_dst_wdata;
    logic          cfg_dst_re;
    logic [3:0]    cfg_dst_raddr;
    logic          cfg_dst_rready;
    logic          cfg_dst_rvalid;
    logic [DW:0]   cfg_dst_rdata;
    logic [15:0]   sent_cnt;

    spk_out_mc dut (
        .clk(clk), .rst(rst), .port(bus),
        .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .cfg_full(cfg_full),
        .cfg_base_we(cfg_base_we), .cfg_base_ch(cfg_base_ch),
        .cfg_base_wdata(cfg_base_wdata),
        .cfg_dst_we(cfg_dst_we), .cfg_dst_waddr(cfg_dst_waddr),
        .cfg_dst_wdata(cfg_dst_wdata),
        .cfg_dst_re(cfg_dst_re), .cfg_dst_raddr(cfg_dst_raddr),
        .cfg_dst_rready(cfg_dst_rready), .cfg_dst_rvalid(cfg_dst_rvalid),
        .cfg_dst_rdata(cfg_dst_rdata), .sent_cnt(sent_cnt)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    logic [FW-1:0] fq[$];
    int fc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.flit_out_wr) begin
            fq.push_back(bus.flit_out);
            fc.push_back(cyc);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fq.delete();
        fc.delete();
    endtask

    task automatic wr_tbl(input logic [3:0] a, input logic [DW:0] d);
        @(negedge clk);
        cfg_dst_we = 1'b1;
        cfg_dst_waddr = a;
        cfg_dst_wdata = d;
        @(posedge clk);
        #1 cfg_dst_we = 1'b0;
    endtask

    task automatic wr_base(input logic [1:0] c, input logic [3:0] b);
        @(negedge clk);
        cfg_base_we = 1'b1;
        cfg_base_ch = c;
        cfg_base_wdata = b;
        @(posedge clk);
        #1 cfg_base_we = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        bus.soma_fire = 4'hF;
        #1;
        checks++;
        if (bus.soma_ready !== 4'h0)
            $display("FAIL reset_ready got %h exp 0", bus.soma_ready);
        else passes++;
        bus.soma_fire = 4'h0;
        checks++;
        if (bus.flit_out_wr !== 1'b0 || bus.flit_out !== '0)
            $display("FAIL reset_flit got %b/%h exp 0/0", bus.flit_out_wr, bus.flit_out);
        else passes++;
        checks++;
        if (sent_cnt !== 16'd0 || cfg_full !== 1'b0)
            $display("FAIL reset_cnt got %h/%b exp 0/0", sent_cnt, cfg_full);
        else passes++;
        checks++;
        if (cfg_dst_rvalid !== 1'b0 || cfg_dst_rready !== 1'b1)
            $display("FAIL reset_rd got %b/%b exp 0/1", cfg_dst_rvalid, cfg_dst_rready);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_cfg_read();
        wr_tbl(4'd5, 21'h12345);
        @(negedge clk);
        cfg_dst_re = 1'b1;
        cfg_dst_raddr = 4'd5;
        #1;
        checks++;
        if (cfg_dst_rready !== 1'b1)
            $display("FAIL rd_ready got %b exp 1", cfg_dst_rready);
        else passes++;
        @(posedge clk);
        #1 cfg_dst_re = 1'b0;
        checks++;
        if (cfg_dst_rvalid !== 1'b1 || cfg_dst_rdata !== 21'h12345)
            $display("FAIL rd_data got %b/%h exp 1/12345", cfg_dst_rvalid, cfg_dst_rdata);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (cfg_dst_rvalid !== 1'b0)
            $display("FAIL rd_pulse got %b exp 0", cfg_dst_rvalid);
        else passes++;
        @(negedge clk);
        cfg_dst_we = 1'b1;
        cfg_dst_waddr = 4'd5;
        cfg_dst_wdata = 21'h00F0F;
        cfg_dst_re = 1'b1;
        @(posedge clk);
        #1 cfg_dst_we = 1'b0;
        cfg_dst_re = 1'b0;
        checks++;
        if (cfg_dst_rdata !== 21'h12345)
            $display("FAIL rd_old got %h exp 12345", cfg_dst_rdata);
        else passes++;
        @(negedge clk);
        cfg_dst_re = 1'b1;
        @(posedge clk);
        #1 cfg_dst_re = 1'b0;
        checks++;
        if (cfg_dst_rdata !== 21'h00F0F)
            $display("FAIL rd_new got %h exp 00f0f", cfg_dst_rdata);
        else passes++;
    endtask

    task automatic test_fanout();
        int p0;
        wr_base(2'd1, 4'd4);
        wr_tbl(4'd4, {20'h00011, 1'b0});
        wr_tbl(4'd5, {20'h00022, 1'b1});
        fq.delete();
        fc.delete();
        @(negedge clk);
        bus.soma_fire = 4'b0010;
        bus.soma_neuid = {24'h0, 24'h0, 24'h000ABC, 24'h0};
        #1;
        checks++;
        if (bus.soma_ready !== 4'b0010)
            $display("FAIL fan_grant got %b exp 0010", bus.soma_ready);
        else passes++;
        @(posedge clk);
        #1 p0 = cyc;
        bus.soma_fire = 4'b0;
        for (int i = 0; i < 40 && fq.size() < 2; i++) @(posedge clk);
        repeat (6) @(negedge clk);
        checks++;
        if (fq.size() != 2)
            $display("FAIL fan_count got %0d exp 2", fq.size());
        else passes++;
        if (fq.size() >= 2) begin
            checks++;
            if (fq[0] !== {3'b000, 20'h00011, 36'h000000ABC})
                $display("FAIL fan_flit0 got %h exp %h", fq[0], {3'b000, 20'h00011, 36'h000000ABC});
            else passes++;
            checks++;
            if (fq[1] !== {3'b000, 20'h00022, 36'h000000ABC})
                $display("FAIL fan_flit1 got %h exp %h", fq[1], {3'b000, 20'h00022, 36'h000000ABC});
            else passes++;
            checks++;
            if (fc[0] != p0 + 3 || fc[1] != fc[0] + 2)
                $display("FAIL fan_timing got %0d/%0d exp %0d/%0d", fc[0] - p0, fc[1] - fc[0], 3, 2);
            else passes++;
        end
        checks++;
        if (sent_cnt !== 16'd2)
            $display("FAIL fan_sent got %0d exp 2", sent_cnt);
        else passes++;
    endtask

    task automatic test_raw();
        int p0;
        logic [FW-1:0] rawf;
        rawf = {3'h7, 56'h123};
        fq.delete();
        fc.delete();
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_wdata = rawf;
        bus.soma_fire = 4'b0001;
        #1;
        checks++;
        if (bus.soma_ready !== 4'b0000 || cfg_full !== 1'b0)
            $display("FAIL raw_prio got %b/%b exp 0000/0", bus.soma_ready, cfg_full);
        else passes++;
        @(posedge clk);
        #1 p0 = cyc;
        cfg_we = 1'b0;
        bus.soma_fire = 4'b0;
        repeat (20) @(posedge clk);
        checks++;
        if (fq.size() != 1)
            $display("FAIL raw_count got %0d exp 1", fq.size());
        else passes++;
        if (fq.size() >= 1) begin
            checks++;
            if (fq[0] !== rawf || fc[0] != p0 + 2)
                $display("FAIL raw_flit got %h@%0d exp %h@%0d", fq[0], fc[0] - p0, rawf, 2);
            else passes++;
        end
        checks++;
        if (sent_cnt !== 16'd3)
            $display("FAIL raw_sent got %0d exp 3", sent_cnt);
        else passes++;
    endtask

    task automatic test_round_robin();
        logic [FW-1:0] e;
        do_reset();
        wr_tbl(4'd0, {20'h00077, 1'b1});
        fq.delete();
        fc.delete();
        @(negedge clk);
        bus.soma_fire = 4'hF;
        bus.soma_neuid = {24'h000103, 24'h000102, 24'h000101, 24'h000100};
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (bus.soma_ready !== (4'b0001 << k))
                $display("FAIL rr_grant%0d got %b exp %b", k, bus.soma_ready, 4'b0001 << k);
            else passes++;
            @(negedge clk);
        end
        bus.soma_fire = 4'h0;
        for (int i = 0; i < 60 && fq.size() < 4; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        checks++;
        if (fq.size() != 4)
            $display("FAIL rr_count got %0d exp 4", fq.size());
        else passes++;
        for (int k = 0; k < 4 && k < fq.size(); k++) begin
            e = {3'b000, 20'h00077, 12'h000, 24'h000100 + 24'(k)};
            checks++;
            if (fq[k] !== e)
                $display("FAIL rr_flit%0d got %h exp %h", k, fq[k], e);
            else passes++;
        end
    endtask

    task automatic test_wrap_credit();
        int cp;
        logic [3:0] a;
        logic [FW-1:0] e;
        do_reset();
        for (int i = 0; i < 16; i++) wr_tbl(4'(i), {20'h00100 + 20'(i), 1'b0});
        wr_base(2'd2, 4'd15);
        fq.delete();
        fc.delete();
        @(negedge clk);
        bus.soma_fire = 4'b0100;
        bus.soma_neuid = {24'h0, 24'h000055, 24'h0, 24'h0};
        #1;
        checks++;
        if (bus.soma_ready !== 4'b0100)
            $display("FAIL wrap_grant got %b exp 0100", bus.soma_ready);
        else passes++;
        @(posedge clk);
        #1 bus.soma_fire = 4'b0;
        for (int i = 0; i < 200 && fq.size() < 15; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        checks++;
        if (fq.size() != 15)
            $display("FAIL wrap_stall got %0d exp 15", fq.size());
        else passes++;
        for (int k = 0; k < 15 && k < fq.size(); k++) begin
            a = 4'(15 + k);
            e = {3'b000, 20'h00100 + 20'(a), 36'h55};
            checks++;
            if (fq[k] !== e)
                $display("FAIL wrap_flit%0d got %h exp %h", k, fq[k], e);
            else passes++;
        end
        @(negedge clk);
        bus.credit_in = 1'b1;
        @(posedge clk);
        #1 bus.credit_in = 1'b0;
        cp = cyc;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (fq.size() != 16)
            $display("FAIL wrap_credit got %0d exp 16", fq.size());
        else passes++;
        if (fq.size() >= 16) begin
            checks++;
            if (fq[15] !== {3'b000, 20'h0010E, 36'h55} || fc[15] != cp + 1)
                $display("FAIL wrap_last got %h@%0d exp %h@1", fq[15], fc[15] - cp, {3'b000, 20'h0010E, 36'h55});
            else passes++;
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (fq.size() != 16 || sent_cnt !== 16'd16)
            $display("FAIL wrap_end got %0d/%0d exp 16/16", fq.size(), sent_cnt);
        else passes++;
    endtask

    task automatic test_full_reset();
        fq.delete();
        fc.delete();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 16) begin
                checks++;
                if (cfg_full !== 1'b0)
                    $display("FAIL full_early got %b exp 0", cfg_full);
                else passes++;
            end
            cfg_we = 1'b1;
            cfg_wdata = {3'b001, 56'(i)};
        end
        @(negedge clk);
        cfg_we = 1'b0;
        bus.soma_fire = 4'hF;
        #1;
        checks++;
        if (cfg_full !== 1'b1 || bus.soma_ready !== 4'h0)
            $display("FAIL full_flag got %b/%b exp 1/0000", cfg_full, bus.soma_ready);
        else passes++;
        checks++;
        if (fq.size() != 0 || bus.flit_out !== {3'b000, 20'h0010E, 36'h55})
            $display("FAIL full_hold got %0d/%h exp 0/%h", fq.size(), bus.flit_out, {3'b000, 20'h0010E, 36'h55});
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.flit_out !== '0 || bus.flit_out_wr !== 1'b0 || sent_cnt !== 16'd0)
            $display("FAIL rst_flit got %h/%b/%0d exp 0/0/0", bus.flit_out, bus.flit_out_wr, sent_cnt);
        else passes++;
        checks++;
        if (cfg_full !== 1'b0 || bus.soma_ready !== 4'h0 || cfg_dst_rready !== 1'b1)
            $display("FAIL rst_ctl got %b/%b/%b exp 0/0000/1", cfg_full, bus.soma_ready, cfg_dst_rready);
        else passes++;
        bus.soma_fire = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        fq.delete();
        fc.delete();
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (fq.size() != 0 || cfg_full !== 1'b0)
            $display("FAIL rst_drain got %0d/%b exp 0/0", fq.size(), cfg_full);
        else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench timed out");
        $fatal(1);
    end

    initial begin
        cfg_we = 1'b0;
        cfg_wdata = '0;
        cfg_base_we = 1'b0;
        cfg_base_ch = '0;
        cfg_base_wdata = '0;
        cfg_dst_we = 1'b0;
        cfg_dst_waddr = '0;
        cfg_dst_wdata = '0;
        cfg_dst_re = 1'b0;
        cfg_dst_raddr = '0;
        bus.soma_fire = '0;
        bus.soma_neuid = '0;
        bus.credit_in = 1'b0;
        test_reset();
        test_cfg_read();
        test_fanout();
        test_raw();
        test_round_robin();
        test_wrap_credit();
        test_full_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
